vga_text_writer: RTL and testbench

Character-stream front end for the VGA text core. Accepts ASCII bytes over a valid/ready handshake, tracks a cursor, interprets a small set of control codes, clears the screen and lines, and drives the core's `write_char` / `write_char_pos` / `write_char_strobe` port. It replaces the fixed incrementing-character test driver with a parametrised block usable both by the CPU bus bridge and, through `DEMO_PERIOD`, as a self-running screen test.

---
 rtl/vga_text_pkg.sv | 20 ++
 rtl/vga_demo_source.sv | 48 ++++
 rtl/vga_text_writer.sv | 186 ++++++++++++++++++
 tb/tb_vga_text_writer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text writer: FSM states, ASCII codes, default geometry.
package vga_text_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL  = 2'd0,
    ST_IDLE       = 2'd1,
    ST_CLEAR_LINE = 2'd2
  } state_e;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 25;
  localparam int unsigned DEF_ADDR_W = 11;

endpackage

// File: rtl/vga_demo_source.sv
// Self-running byte source: raises a request every PERIOD cycles and holds it until
// accepted, offering an incrementing byte starting at 0x00.
module vga_demo_source #(
  parameter int unsigned PERIOD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready_i,
  output logic [7:0] char_o,
  output logic       valid_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;

  // Free-running period counter; an acceptance takes priority over a new request.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    char_d  = char_q;
    valid_d = valid_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      char_d  = char_q + 8'd1;
    end else if (cnt_q == CNT_LAST) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  assign char_o  = char_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/vga_text_writer.sv
// Character-stream front end for the VGA text core: cursor tracking, control codes,
// screen/line clears, and a registered write port.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEMO_PERIOD = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               in_char,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               write_char,
  output logic [ADDR_W-1:0]        write_char_pos,
  output logic                     write_char_strobe,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [7:0]        wr_char_q, wr_char_d;
  logic [ADDR_W-1:0] wr_pos_q, wr_pos_d;
  logic              wr_stb_q, wr_stb_d;

  logic [7:0]        src_char;
  logic              src_valid;
  logic              accept;
  logic              is_print;
  logic              row_wrap;
  logic [RW-1:0]     row_inc;
  logic [ADDR_W-1:0] base_inc;
  logic [ADDR_W-1:0] cur_pos;

  if (DEMO_PERIOD > 0) begin : g_demo
    logic unused_ext;
    assign unused_ext = ^{in_char, in_valid};
    vga_demo_source #(.PERIOD(DEMO_PERIOD)) u_demo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .ready_i (in_ready),
      .char_o  (src_char),
      .valid_o (src_valid)
    );
  end else begin : g_ext
    assign src_char  = in_char;
    assign src_valid = in_valid;
  end

  assign busy     = (state_q != ST_IDLE);
  assign in_ready = !busy;
  assign accept   = src_valid && in_ready;
  assign is_print = (src_char != CH_LF) && (src_char != CH_CR) &&
                    (src_char != CH_BS) && (src_char != CH_FF);

  // row_base tracks row*COLS so positions need no multiplier.
  assign row_wrap = (row_q == ROW_LAST);
  assign row_inc  = row_wrap ? '0 : row_q + RW'(1);
  assign base_inc = row_wrap ? '0 : row_base_q + COLS_A;
  assign cur_pos  = row_base_q + ADDR_W'(col_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_CLEAR_ALL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR_ALL:  if (clr_idx_q == ALL_LAST)  state_d = ST_IDLE;
      ST_CLEAR_LINE: if (clr_idx_q == LINE_LAST) state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (src_char == CH_LF)                      state_d = ST_CLEAR_LINE;
          else if (src_char == CH_FF)                 state_d = ST_CLEAR_ALL;
          else if (is_print && (col_q == COL_LAST))   state_d = ST_CLEAR_LINE;
        end
      end
      default: state_d = ST_CLEAR_ALL;
    endcase
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    clr_idx_d  = clr_idx_q;
    wr_char_d  = wr_char_q;
    wr_pos_d   = wr_pos_q;
    wr_stb_d   = 1'b0;
    case (state_q)
      ST_CLEAR_ALL: begin
        wr_stb_d  = 1'b1;
        wr_char_d = CH_SPACE;
        wr_pos_d  = clr_idx_q;
        clr_idx_d = (clr_idx_q == ALL_LAST) ? '0 : clr_idx_q + ADDR_W'(1);
      end
      ST_CLEAR_LINE: begin
        wr_stb_d  = 1'b1;
        wr_char_d = CH_SPACE;
        wr_pos_d  = row_base_q + clr_idx_q;
        clr_idx_d = (clr_idx_q == LINE_LAST) ? '0 : clr_idx_q + ADDR_W'(1);
      end
      ST_IDLE: begin
        if (accept) begin
          case (src_char)
            CH_LF: begin
              col_d      = '0;
              row_d      = row_inc;
              row_base_d = base_inc;
            end
            CH_CR: col_d = '0;
            CH_BS: begin
              if (col_q != '0) begin
                col_d     = col_q - CW'(1);
                wr_stb_d  = 1'b1;
                wr_char_d = CH_SPACE;
                wr_pos_d  = cur_pos - ADDR_W'(1);
              end
            end
            CH_FF: begin
              col_d      = '0;
              row_d      = '0;
              row_base_d = '0;
            end
            default: begin
              wr_stb_d  = 1'b1;
              wr_char_d = src_char;
              wr_pos_d  = cur_pos;
              if (col_q == COL_LAST) begin
                col_d      = '0;
                row_d      = row_inc;
                row_base_d = base_inc;
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      clr_idx_q  <= '0;
      wr_char_q  <= 8'h00;
      wr_pos_q   <= '0;
      wr_stb_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      clr_idx_q  <= clr_idx_d;
      wr_char_q  <= wr_char_d;
      wr_pos_q   <= wr_pos_d;
      wr_stb_q   <= wr_stb_d;
    end
  end

  assign write_char        = wr_char_q;
  assign write_char_pos    = wr_pos_q;
  assign write_char_strobe = wr_stb_q;
  assign cursor_col        = col_q;
  assign cursor_row        = row_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer on a 4x3 screen, plus a demo-mode instance.
module tb_vga_text_writer;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 3;
  localparam int unsigned AW   = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready, stb, busy;
  logic [7:0] wchar;
  logic [AW-1:0] wpos;
  logic [1:0] ccol, crow;

  logic       d_ready, d_stb, d_busy;
  logic [7:0] d_char;
  logic [AW-1:0] d_pos;
  logic [1:0] d_col, d_row;

  int checks = 0;
  int errors = 0;
  logic [11:0] dq[$];

  always #5 CLK = ~CLK;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .DEMO_PERIOD(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .write_char(wchar), .write_char_pos(wpos),
    .write_char_strobe(stb), .cursor_col(ccol), .cursor_row(crow), .busy(busy)
  );

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .DEMO_PERIOD(3)) dut_demo (
    .CLK(CLK), .RST_N(RST_N), .in_char(8'h41), .in_valid(1'b1),
    .in_ready(d_ready), .write_char(d_char), .write_char_pos(d_pos),
    .write_char_strobe(d_stb), .cursor_col(d_col), .cursor_row(d_row), .busy(d_busy)
  );

  // Record non-clear writes from the demo instance; restart on every reset.
  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) dq.delete();
    else if (d_stb && d_char != 8'h20) dq.push_back({d_char, d_pos});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    chk("send_rdy", 32'(in_ready), 32'd1);
    in_char  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] c, input logic [AW-1:0] p);
    chk({tag, "_stb"}, 32'(stb), 32'd1);
    chk({tag, "_chr"}, 32'(wchar), 32'(c));
    chk({tag, "_pos"}, 32'(wpos), 32'(p));
  endtask

  task automatic chk_cur(input string tag, input int col, input int row);
    chk({tag, "_col"}, 32'(ccol), 32'(col));
    chk({tag, "_row"}, 32'(crow), 32'(row));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"}, 32'(stb), 32'd0);
    chk({tag, "_chr"}, 32'(wchar), 32'd0);
    chk({tag, "_pos"}, 32'(wpos), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    chk_cur(tag, 0, 0);
  endtask

  // n consecutive space writes from base; idle and ready right after the last one.
  task automatic clear_seq(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_wr(tag, 8'h20, AW'(base + i));
      chk({tag, "_busy"}, 32'(busy), (i < n - 1) ? 32'd1 : 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready), (i < n - 1) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    in_char  = 8'h00;
    in_valid = 1'b0;
    #2;
    chk_reset_vals("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    clear_seq("clrall", 0, 12);
    tick();
    chk("idle_nostb", 32'(stb), 32'd0);

    // "AB", CR, "C"
    send(8'h41); chk_wr("A", 8'h41, 0); chk_cur("A", 1, 0);
    send(8'h42); chk_wr("B", 8'h42, 1); chk_cur("B", 2, 0);
    send(8'h0D); chk("cr_nostb", 32'(stb), 32'd0); chk_cur("cr", 0, 0);
    send(8'h43); chk_wr("C", 8'h43, 0); chk_cur("C", 1, 0);

    // Backspace at column 0 and column 2
    send(8'h0D);
    send(8'h08); chk("bs0_nostb", 32'(stb), 32'd0); chk_cur("bs0", 0, 0);
    send(8'h58); chk_wr("X", 8'h58, 0);
    send(8'h59); chk_wr("Y", 8'h59, 1); chk_cur("Y", 2, 0);
    send(8'h08); chk_wr("bs2", 8'h20, 1); chk_cur("bs2", 1, 0);

    // LF twice, then fill row 2 and wrap
    send(8'h0A); chk("lf_nostb", 32'(stb), 32'd0); chk_cur("lf1", 0, 1);
    chk("lf_busy", 32'(busy), 32'd1);
    clear_seq("lf1clr", 4, 4);
    send(8'h0A); chk_cur("lf2", 0, 2);
    clear_seq("lf2clr", 8, 4);
    send(8'h61); chk_wr("a", 8'h61, 8);
    send(8'h62); chk_wr("b", 8'h62, 9);
    send(8'h63); chk_wr("c", 8'h63, 10);
    send(8'h64); chk_wr("d", 8'h64, 11); chk_cur("wrap", 0, 0);
    chk("wrap_busy", 32'(busy), 32'd1);
    clear_seq("wrapclr", 0, 4);

    // Form feed mid-screen with a byte held valid through the clear
    send(8'h51); chk_wr("Q", 8'h51, 0);
    in_char  = 8'h0C;
    in_valid = 1'b1;
    tick();
    chk("ff_nostb", 32'(stb), 32'd0); chk_cur("ff", 0, 0);
    chk("ff_busy", 32'(busy), 32'd1);
    in_char = 8'h5A;
    clear_seq("ffclr", 0, 12);
    tick();
    chk_wr("Z", 8'h5A, 0);
    in_valid = 1'b0;
    chk_cur("Z", 1, 0);

    // Reset pulse in the middle of a line clear
    send(8'h0A);
    tick(); chk_wr("mid0", 8'h20, 4);
    tick(); chk_wr("mid1", 8'h20, 5);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    clear_seq("reclr", 0, 12);
    chk_cur("reclr", 0, 0);

    // Demo instance: bytes 0x00.. written at consecutive positions after its clear
    repeat (40) tick();
    chk("demo_cnt", 32'(dq.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < dq.size()) begin
        chk("demo_chr", 32'(dq[i][11:4]), 32'(i));
        chk("demo_pos", 32'(dq[i][3:0]), 32'(i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
